// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through IF/ID/EX/MEM/WB
// and drives the datapath enables, stalling on the shared memory ready handshake.
module multicycle_ctrl #(
    parameter int OPC_W       = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             retire,
    output logic             illegal_op,
    output logic             bus_err
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OPC_W-1:0] OP_R   = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW  = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_SW  = OPC_W'(6'b001001);
    localparam logic [OPC_W-1:0] OP_BEQ = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_J   = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_JR  = OPC_W'(6'b000101);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3, S_MEM = 3'd4, S_WB = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_R, C_LW, C_SW, C_BEQ, C_J, C_JR, C_ILL
    } opc_t;

    state_t           r_state, w_next, w_ret_tgt;
    opc_t             r_class, w_dec;
    logic [CNT_W-1:0] r_wait;
    logic             w_timeout;

    always_comb begin
        case (opcode)
            OP_R:    w_dec = C_R;
            OP_LW:   w_dec = C_LW;
            OP_SW:   w_dec = C_SW;
            OP_BEQ:  w_dec = C_BEQ;
            OP_J:    w_dec = C_J;
            OP_JR:   w_dec = C_JR;
            default: w_dec = C_ILL;
        endcase
    end

    assign w_timeout = ((r_state == S_IF) || (r_state == S_MEM)) &&
                       (r_wait == CNT_W'(MEM_TIMEOUT));
    assign w_ret_tgt = en ? S_IF : S_IDLE;
    assign state     = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_class <= C_NOP;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID)
                r_class <= w_dec;
            // Any state change (including entry to IF/MEM) restarts the wait count
            if (w_next != r_state)
                r_wait <= '0;
            else if (((r_state == S_IF) || (r_state == S_MEM)) && !mem_ready)
                r_wait <= r_wait + 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_op     = 2'b00;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        case (r_state)
            S_IDLE: if (en) w_next = S_IF;
            S_IF: begin
                if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_next   = S_ID;
                    end
                end
            end
            S_ID: begin
                if (w_dec == C_ILL) begin
                    illegal_op = 1'b1;
                    retire     = 1'b1;
                    w_next     = w_ret_tgt;
                end else begin
                    w_next = S_EX;
                end
            end
            S_EX: begin
                case (r_class)
                    C_R: begin
                        alu_op = 2'b10;
                        w_next = S_WB;
                    end
                    C_LW, C_SW: w_next = S_MEM;
                    C_BEQ: begin
                        alu_op   = 2'b01;
                        pc_src   = 2'b01;
                        pc_write = zero;
                        retire   = 1'b1;
                        w_next   = w_ret_tgt;
                    end
                    C_J, C_JR: begin
                        pc_src   = (r_class == C_J) ? 2'b10 : 2'b11;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        w_next   = w_ret_tgt;
                    end
                    default: w_next = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    iord      = 1'b1;
                    mem_read  = (r_class == C_LW);
                    mem_write = (r_class == C_SW);
                    if (mem_ready) begin
                        if (r_class == C_SW) begin
                            retire = 1'b1;
                            w_next = w_ret_tgt;
                        end else begin
                            w_next = S_WB;
                        end
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                reg_dst    = (r_class == C_R);
                mem_to_reg = (r_class == C_LW);
                w_next     = w_ret_tgt;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: an instruction-level trace model expands each instruction into
// its expected per-cycle input/output records; one compare loop plays them.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, en, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, ir_write, iord, mem_read, mem_write;
    logic       reg_dst, reg_write, mem_to_reg, retire, illegal_op, bus_err;
    logic [1:0] pc_src, alu_op;
    logic [2:0] state;

    multicycle_ctrl #(.OPC_W(6), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .alu_op(alu_op), .reg_dst(reg_dst), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .state(state), .retire(retire),
        .illegal_op(illegal_op), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    wire [17:0] act = {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                       alu_op, reg_dst, reg_write, mem_to_reg, retire, illegal_op, bus_err};

    localparam logic [17:0] PCW = 18'h04000, IRW = 18'h00800, IORD = 18'h00400;
    localparam logic [17:0] MR = 18'h00200, MW = 18'h00100, RD = 18'h00020;
    localparam logic [17:0] RW = 18'h00010, M2R = 18'h00008, RET = 18'h00004;
    localparam logic [17:0] ILL = 18'h00002, BERR = 18'h00001;

    function automatic logic [17:0] ST(input int s);   return {s[2:0], 15'b0}; endfunction
    function automatic logic [17:0] PSRC(input int v); return {4'b0, v[1:0], 12'b0}; endfunction
    function automatic logic [17:0] ALU(input int v);  return {10'b0, v[1:0], 6'b0}; endfunction
    function automatic bit rnd(); return bit'($urandom_range(0, 1)); endfunction

    typedef struct {
        bit         en;
        logic [5:0] opc;
        bit         zero;
        bit         rdy;
        logic [17:0] exp;
    } cyc_t;

    cyc_t q[$];
    int   nchk = 0, nerr = 0, cyc = 0;

    task automatic push(input bit e, input logic [5:0] o, input bit z, input bit r,
                        input logic [17:0] x);
        cyc_t c;
        c.en = e; c.opc = o; c.zero = z; c.rdy = r; c.exp = x;
        q.push_back(c);
    endtask

    task automatic add_idle(input int n, input bit en_last);
        for (int i = 0; i < n; i++)
            push((i == n - 1) ? en_last : 1'b0, 6'h3f, rnd(), rnd(), ST(0));
    endtask

    // Expected trace of one instruction; en_after also drives en mid-instruction
    task automatic add_instr(input logic [5:0] o, input bit z, input int if_wait,
                             input int mem_wait, input bit ea);
        for (int k = 0; k < if_wait && k < 15; k++) push(ea, o, rnd(), 1'b0, ST(1) | MR);
        if (if_wait >= 15) begin
            push(ea, o, rnd(), 1'b0, ST(1) | BERR);
            return;
        end
        push(ea, o, rnd(), 1'b1, ST(1) | MR | IRW | PCW | PSRC(0));
        if (!(o inside {6'b000000, 6'b001000, 6'b001001, 6'b000100, 6'b000010, 6'b000101})) begin
            push(ea, o, rnd(), rnd(), ST(2) | RET | ILL);
            return;
        end
        push(ea, o, rnd(), rnd(), ST(2));
        case (o)
            6'b000000: begin
                push(ea, o, rnd(), rnd(), ST(3) | ALU(2));
                push(ea, o, rnd(), rnd(), ST(5) | RW | RD | RET);
            end
            6'b000100: push(ea, o, z, rnd(), ST(3) | ALU(1) | PSRC(1) | (z ? PCW : 18'h0) | RET);
            6'b000010: push(ea, o, rnd(), rnd(), ST(3) | PSRC(2) | PCW | RET);
            6'b000101: push(ea, o, rnd(), rnd(), ST(3) | PSRC(3) | PCW | RET);
            default: begin
                logic [17:0] strobe;
                strobe = (o == 6'b001000) ? MR : MW;
                push(ea, o, rnd(), rnd(), ST(3) | ALU(0));
                for (int k = 0; k < mem_wait && k < 15; k++)
                    push(ea, o, rnd(), 1'b0, ST(4) | IORD | strobe);
                if (mem_wait >= 15) begin
                    push(ea, o, rnd(), 1'b0, ST(4) | BERR);
                    return;
                end
                if (o == 6'b001000) begin
                    push(ea, o, rnd(), 1'b1, ST(4) | IORD | MR);
                    push(ea, o, rnd(), rnd(), ST(5) | RW | M2R | RET);
                end else begin
                    push(ea, o, rnd(), 1'b1, ST(4) | IORD | MW | RET);
                end
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [17:0] got, input logic [17:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic chki(input string name, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_seg(input string name, input int ncyc, input int nret);
        int r;
        cyc_t c;
        r = 0;
        chki({name, " length"}, q.size(), ncyc);
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            en = c.en; opcode = c.opc; zero = c.zero; mem_ready = c.rdy;
            @(negedge clk);
            cyc++;
            chk(name, act, c.exp);
            if (retire) r++;
        end
        chki({name, " retires"}, r, nret);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        #3;
        chk("reset", act, 18'h0);
        @(negedge clk);
        rst_n = 1'b1;

        add_idle(1, 1'b1); add_instr(6'b000000, 1'b0, 0, 0, 1'b1);
        run_seg("rtype", 5, 1);
        add_instr(6'b001000, 1'b0, 0, 2, 1'b1);
        run_seg("lw", 7, 1);
        add_instr(6'b000100, 1'b1, 0, 0, 1'b1); add_instr(6'b000100, 1'b0, 0, 0, 1'b1);
        run_seg("beq", 6, 2);
        add_instr(6'b001111, 1'b0, 0, 0, 1'b1);
        run_seg("illegal", 2, 1);
        add_instr(6'b000010, 1'b0, 1, 0, 1'b1); add_instr(6'b000101, 1'b0, 1, 0, 1'b0);
        run_seg("j_jr", 8, 2);
        add_idle(2, 1'b1); add_instr(6'b001001, 1'b0, 0, 1, 1'b1);
        run_seg("sw", 7, 1);
        add_instr(6'b001001, 1'b0, 0, 15, 1'b1);
        run_seg("sw_timeout", 19, 0);
        add_idle(1, 1'b1); add_instr(6'b000000, 1'b0, 15, 0, 1'b1);
        run_seg("if_timeout", 17, 0);
        add_idle(1, 1'b1); add_instr(6'b000000, 1'b0, 0, 0, 1'b0);
        run_seg("en_low", 5, 1);

        // Asynchronous reset while a store is in MEM
        @(posedge clk); #1 en = 1'b1; opcode = 6'b001001; mem_ready = 1'b0;
        @(posedge clk); #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("sw_in_mem", act, 18'h20500);
        rst_n = 1'b0;
        #1;
        chk("rst_async", act, 18'h0);
        en = 1'b0;
        @(negedge clk);
        chk("rst_held", act, 18'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_after_rst", act, 18'h0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the single-issue datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives the per-cycle datapath enables, and stalls on a shared instruction/data memory ready handshake.
- Sits between the instruction register (opcode source) and the PC, IR, register-file, ALU and memory control inputs.
- Replaces the purely combinational opcode decode with a sequenced control path.

Parameters:
- OPC_W, 6, opcode width.
- MEM_TIMEOUT, 15, maximum mem_ready wait cycles before the bus_err pulse (4-bit counter).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable; sampled only in IDLE and on instruction retire.
- opcode  input  OPC_W  IR[31:26]; valid from the ID state onward.
- zero  input  1  ALU zero flag, used in EX for beq.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  PC register load.
- pc_src  output  2  PC mux select: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs register.
- ir_write  output  1  IR load.
- iord  output  1  memory address select: 0 = PC, 1 = ALU result.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- alu_op  output  2  00 = add, 01 = sub (compare), 10 = funct-decoded.
- reg_dst  output  1  1 = rd destination, 0 = rt destination.
- reg_write  output  1  register-file write enable.
- mem_to_reg  output  1  writeback data select: 1 = memory, 0 = ALU.
- state  output  3  current state code, for debug.
- retire  output  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  output  1  one-cycle pulse when an undefined opcode is decoded.
- bus_err  output  1  one-cycle pulse on memory timeout.

Behaviour:
- State encoding: IDLE = 0, IF = 1, ID = 2, EX = 3, MEM = 4, WB = 5.
- All registers are reset asynchronously on rst_n low. Reset values:
  - state = IDLE, op_class = NOP, wait counter = 0.
  - Every output is 0.
- All outputs are decoded combinationally from the registered state and the latched op_class. Only pc_write (in EX) and the memory-stage advance also depend on the live zero and mem_ready inputs.
- Opcode map:
  - 000000 R-type (add/sub via funct).
  - 001000 lw.
  - 001001 sw.
  - 000100 beq.
  - 000010 j.
  - 000101 jr.
  - Any other value is illegal.
- IDLE: all outputs 0. Go to IF when en = 1.
- IF: mem_read = 1, iord = 0.
  - While mem_ready = 0, stay in IF and increment the wait counter.
  - On mem_ready = 1: ir_write = 1, pc_write = 1 with pc_src = 00, then go to ID.
- ID: latch the opcode into op_class.
  - Illegal opcode: pulse illegal_op and retire, write nothing, then go to IF (or IDLE if en = 0).
  - Otherwise go to EX.
- EX, by op_class:
  - R-type: alu_op = 10, then go to WB.
  - lw / sw: alu_op = 00, then go to MEM.
  - beq: alu_op = 01, pc_src = 01, pc_write = zero, retire = 1, then go to IF.
  - j: pc_src = 10, pc_write = 1, retire = 1, then go to IF.
  - jr: pc_src = 11, pc_write = 1, retire = 1, then go to IF.
- MEM: iord = 1.
  - lw holds mem_read = 1; sw holds mem_write = 1.
  - Hold the strobe until mem_ready = 1.
  - On mem_ready, sw retires and goes to IF; lw goes to WB.
- WB: reg_write = 1, retire = 1, then go to IF.
  - R-type: reg_dst = 1, mem_to_reg = 0.
  - lw: reg_dst = 0, mem_to_reg = 1.
- Retire target: every retire goes to IF if en = 1, or to IDLE if en = 0.
- Latency with zero-wait memory (IF counts 1 cycle):
  - R-type 4 cycles, lw 5, sw 4, beq/j/jr 3, illegal 2.
  - Each memory wait cycle adds 1 cycle.
- Memory timeout:
  - The wait counter clears on entry to IF or MEM and counts each cycle that mem_ready = 0.
  - When it reaches MEM_TIMEOUT: pulse bus_err, drop all strobes, go to IDLE. No retire pulse.
- Strobe rules:
  - mem_read and mem_write are never high together.
  - ir_write is asserted only in IF.
  - reg_write is asserted only in WB.
- A mem_ready arriving outside IF or MEM is ignored.
- en deasserted mid-instruction does not abort; the instruction completes first.
- rst_n asserted mid-instruction: outputs return to 0 immediately (asynchronously); no partial write may complete after the reset edge.

Test Plan:
- Reset, then en = 1, opcode = 000000, mem_ready = 1 constantly → states 1, 2, 3, 5, then 1; alu_op = 10 in EX; reg_write = 1 and reg_dst = 1 in WB; retire pulses in cycle 4.
- lw (001000) with mem_ready low for 2 cycles in MEM → mem_read and iord = 1 held 3 cycles; WB has mem_to_reg = 1 and reg_dst = 0; total 7 cycles.
- beq (000100) with zero = 1, then repeat with zero = 0 → in EX, pc_src = 01 both times; pc_write = 1 then 0; retire after 3 cycles; no reg_write.
- Opcode = 001111 → illegal_op and retire pulse in ID; no reg_write, mem_write or pc_write after IF; next state IF.
- sw (001001) with mem_ready held 0 → after 15 wait cycles bus_err pulses; state = IDLE; mem_write = 0.
- rst_n low during the MEM state of a sw → mem_write drops the same cycle; state = 0; after release with en = 0, the block stays in IDLE.
